// File: rtl/top_k_stream_unpacker_pkg.sv
// Shared constants, FSM encoding and lane helpers for the top-k integer stream path.
// The lane-select helper is also used by top_k_block's packing side.
package top_k_pkg;

    localparam int INTEGER_SIZE = 32;
    localparam int BUS_WIDTH    = 512;
    localparam int LANES        = BUS_WIDTH / INTEGER_SIZE;
    localparam int IDX_W        = $clog2(LANES);
    localparam int KEEP_W       = BUS_WIDTH / 8;

    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } state_e;

    function automatic logic [INTEGER_SIZE-1:0] lane_sel(
        input logic [BUS_WIDTH-1:0] word,
        input logic [IDX_W-1:0]     idx
    );
        return word[idx*INTEGER_SIZE +: INTEGER_SIZE];
    endfunction

    // A lane counts only when every one of its bytes is kept.
    function automatic logic [LANES-1:0] keep_to_mask(input logic [KEEP_W-1:0] keep);
        logic [LANES-1:0] mask;
        mask = '0;
        for (int l = 0; l < LANES; l++) begin
            mask[l] = &keep[l*(INTEGER_SIZE/8) +: (INTEGER_SIZE/8)];
        end
        return mask;
    endfunction

    function automatic logic [IDX_W-1:0] first_lane(input logic [LANES-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (mask[l]) idx = IDX_W'(l);
        end
        return idx;
    endfunction

endpackage

// File: rtl/top_k_stream_unpacker_if.sv
// Network receive stream in, integer stream out. The unpacker uses the slave view;
// the upstream/downstream environment uses the master view.
// Handshakes: a beat transfers on a clock edge where valid && ready; a source
// holds its payload stable while valid is high and ready is low.
interface top_k_stream_unpacker_if;

    logic [top_k_pkg::BUS_WIDTH-1:0]    s_axis_rx_tdata;
    logic [top_k_pkg::KEEP_W-1:0]       s_axis_rx_tkeep;
    logic                               s_axis_rx_tvalid;
    logic                               s_axis_rx_tlast;
    logic                               s_axis_rx_tready;
    logic [top_k_pkg::INTEGER_SIZE-1:0] m_axis_int_tdata;
    logic                               m_axis_int_tvalid;
    logic                               m_axis_int_tlast;
    logic                               m_axis_int_tuser;
    logic                               m_axis_int_tready;

    modport master (
        output s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tvalid, s_axis_rx_tlast,
        input  s_axis_rx_tready,
        input  m_axis_int_tdata, m_axis_int_tvalid, m_axis_int_tlast, m_axis_int_tuser,
        output m_axis_int_tready
    );

    modport slave (
        input  s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tvalid, s_axis_rx_tlast,
        output s_axis_rx_tready,
        output m_axis_int_tdata, m_axis_int_tvalid, m_axis_int_tlast, m_axis_int_tuser,
        input  m_axis_int_tready
    );

endinterface

// File: rtl/top_k_stream_unpacker_lane_scan.sv
// Combinational lane scan: validity of the current lane, the next valid lane above it,
// and whether no valid lane remains above it in the buffered word.
module top_k_lane_scan
    import top_k_pkg::*;
(
    input  logic [LANES-1:0] mask_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             cur_valid_o,
    output logic [IDX_W-1:0] next_idx_o,
    output logic             is_last_o
);

    always_comb begin
        cur_valid_o = mask_i[idx_i];
        next_idx_o  = idx_i;
        is_last_o   = 1'b1;
        // Descending walk so the lowest valid lane above idx_i wins.
        for (int l = LANES - 1; l >= 0; l--) begin
            if (l > int'(idx_i) && mask_i[l]) begin
                next_idx_o = IDX_W'(l);
                is_last_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/top_k_stream_unpacker.sv
// Splits the 512-bit receive stream into one 32-bit integer per beat, framing each
// batch (header count N, then N integers) with tuser on the first and tlast on the last.
module top_k_stream_unpacker
    import top_k_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    top_k_stream_unpacker_if.slave  bus,
    output logic [31:0]             batch_count
);

    state_e                  state_q, state_d;
    logic [BUS_WIDTH-1:0]    buf_q, buf_d;
    logic [LANES-1:0]        mask_q, mask_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [INTEGER_SIZE-1:0] rem_q, rem_d;
    logic                    first_q, first_d;
    logic [31:0]             batch_count_q, batch_count_d;

    logic                    cur_valid;
    logic [IDX_W-1:0]        next_idx;
    logic                    is_last;
    logic [INTEGER_SIZE-1:0] lane;
    logic                    cur_ok;
    logic                    consume;
    logic                    rx_ready;
    logic [LANES-1:0]        new_mask;

    top_k_lane_scan u_scan (
        .mask_i      (mask_q),
        .idx_i       (idx_q),
        .cur_valid_o (cur_valid),
        .next_idx_o  (next_idx),
        .is_last_o   (is_last)
    );

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        mask_d        = mask_q;
        buf_valid_d   = buf_valid_q;
        idx_d         = idx_q;
        rem_d         = rem_q;
        first_d       = first_q;
        batch_count_d = batch_count_q;

        lane     = lane_sel(buf_q, idx_q);
        cur_ok   = buf_valid_q && cur_valid;
        // Headers are swallowed internally; data lanes need the downstream ready.
        consume  = cur_ok && ((state_q == HDR) || bus.m_axis_int_tready);
        rx_ready = !buf_valid_q || (consume && is_last);
        new_mask = keep_to_mask(bus.s_axis_rx_tkeep);

        if (consume) begin
            if (is_last) buf_valid_d = 1'b0;
            else         idx_d       = next_idx;

            if (state_q == HDR) begin
                rem_d = lane;
                if (lane == '0) begin
                    batch_count_d = batch_count_q + 32'd1;
                end else begin
                    state_d = DATA;
                    first_d = 1'b1;
                end
            end else begin
                rem_d   = rem_q - 1'b1;
                first_d = 1'b0;
                if (rem_q == 1) begin
                    state_d       = HDR;
                    batch_count_d = batch_count_q + 32'd1;
                end
            end
        end

        // A word with no fully kept lane is accepted and dropped.
        if (bus.s_axis_rx_tvalid && rx_ready && (new_mask != '0)) begin
            buf_d       = bus.s_axis_rx_tdata;
            mask_d      = new_mask;
            buf_valid_d = 1'b1;
            idx_d       = first_lane(new_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HDR;
            buf_q         <= '0;
            mask_q        <= '0;
            buf_valid_q   <= 1'b0;
            idx_q         <= '0;
            rem_q         <= '0;
            first_q       <= 1'b0;
            batch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            mask_q        <= mask_d;
            buf_valid_q   <= buf_valid_d;
            idx_q         <= idx_d;
            rem_q         <= rem_d;
            first_q       <= first_d;
            batch_count_q <= batch_count_d;
        end
    end

    assign bus.s_axis_rx_tready  = rx_ready;
    assign bus.m_axis_int_tvalid = (state_q == DATA) && cur_ok;
    assign bus.m_axis_int_tdata  = lane;
    assign bus.m_axis_int_tuser  = (state_q == DATA) && first_q;
    assign bus.m_axis_int_tlast  = (state_q == DATA) && (rem_q == 1);
    assign batch_count           = batch_count_q;

endmodule
